light_phase_scheduler: RTL and testbench

- Sequences the two-road intersection phases (through green, yellow, protected left turn) and generates per-road lamp drives plus a seconds countdown for the seven-segment and VGA status display.
- Owns the second-tick generator, the per-phase durations (scaled by flowspeed) and arbitration of the four left-turn requests into the two road slots.
- Sits between the board switches/buttons and the lamp, display and VGA drivers inside trafficlight.

---
 rtl/light_phase_if.sv | 25 ++
 rtl/light_phase_scheduler.sv | 148 ++++++++++++++
 tb/tb_light_phase_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/light_phase_if.sv
// Board-side bundle for the intersection phase scheduler: controls in, lamp/display status out.
interface light_phase_if;
    logic       count_en;
    logic [1:0] speed_select;
    logic [2:0] flowspeed;
    logic       SW;
    logic [3:0] turn_left_req;
    logic       Red1, Yellow1, Green1, Left1;
    logic       Red2, Yellow2, Green2, Left2;
    logic [7:0] countdown;
    logic [2:0] phase;
    logic       sec_tick;

    modport master (
        output count_en, speed_select, flowspeed, SW, turn_left_req,
        input  Red1, Yellow1, Green1, Left1, Red2, Yellow2, Green2, Left2,
        input  countdown, phase, sec_tick
    );

    modport slave (
        input  count_en, speed_select, flowspeed, SW, turn_left_req,
        output Red1, Yellow1, Green1, Left1, Red2, Yellow2, Green2, Left2,
        output countdown, phase, sec_tick
    );
endinterface

// File: rtl/light_phase_scheduler.sv
// Two-road phase sequencer with second-tick divider, left-turn arbitration and countdown.
// Optional night flash mode: define LIGHT_PHASE_NIGHT_FLASH_EN.
module light_phase_scheduler #(
    parameter int TICK_DIV = 16,
    parameter int GREEN_T  = 30,
    parameter int YELLOW_T = 3,
    parameter int LEFT_T   = 10
) (
    input  logic          CLK,
    input  logic          Reset1,
    light_phase_if.slave  bus
);
    localparam int TW = $clog2(TICK_DIV);
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
    localparam int SB = 4;
`else
    localparam int SB = 3;
`endif

    typedef enum logic [SB-1:0] {
        G1, Y1, L1, LY1, G2, Y2, L2, LY2
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
        , FLASH
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          tick_hit, sec_tick_q;
    logic [7:0]    cnt_q, cnt_d;
    logic          pend1_q, pend1_d, pend2_q, pend2_d;
    logic [7:0]    lamps_q, lamps_d;
    logic [7:0]    green_ld;
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
    logic          flash_q, flash_d;
`endif

    assign green_ld = 8'(GREEN_T) + {4'b0, bus.flowspeed, 1'b0};
    assign tick_hit = bus.count_en && (tick_q == '0);

    always_comb begin
        tick_d = tick_q;
        if (bus.count_en)
            tick_d = (tick_q == '0) ? TW'((TICK_DIV >> bus.speed_select) - 1) : tick_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend1_d = pend1_q | (|bus.turn_left_req[1:0]);
        pend2_d = pend2_q | (|bus.turn_left_req[3:2]);
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
        flash_d = flash_q;
`endif
        if (tick_hit) begin
            if (cnt_q > 8'd1) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                case (state_q)
                    G1:      state_d = Y1;
                    Y1:      state_d = pend1_q ? L1 : G2;
                    L1:      state_d = LY1;
                    LY1:     state_d = G2;
                    G2:      state_d = Y2;
                    Y2:      state_d = pend2_q ? L2 : G1;
                    L2:      state_d = LY2;
                    default: state_d = G1;
                endcase
                case (state_d)
                    G1, G2:  cnt_d = green_ld;
                    L1, L2:  cnt_d = 8'(LEFT_T);
                    default: cnt_d = 8'(YELLOW_T);
                endcase
            end
        end
        // Entering a left phase serves the request; this beats a same-cycle set.
        if (state_d == L1 && state_q != L1) pend1_d = 1'b0;
        if (state_d == L2 && state_q != L2) pend2_d = 1'b0;
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
        if (bus.SW) begin
            state_d = FLASH;
            cnt_d   = 8'd0;
            pend1_d = 1'b0;
            pend2_d = 1'b0;
            flash_d = (state_q == FLASH) ? (flash_q ^ tick_hit) : 1'b0;
        end else if (state_q == FLASH) begin
            state_d = FLASH;
            cnt_d   = 8'd0;
            pend1_d = 1'b0;
            pend2_d = 1'b0;
            if (tick_hit) begin
                state_d = G1;
                cnt_d   = green_ld;
                flash_d = 1'b0;
            end
        end
`endif
    end

    // Lamp vector order: {Red1, Yellow1, Green1, Left1, Red2, Yellow2, Green2, Left2}
    always_comb begin
        lamps_d = 8'b0;
        case (state_d)
            G1:       lamps_d = 8'b0010_1000;
            Y1, LY1:  lamps_d = 8'b0100_1000;
            L1:       lamps_d = 8'b1001_1000;
            G2:       lamps_d = 8'b1000_0010;
            Y2, LY2:  lamps_d = 8'b1000_0100;
            L2:       lamps_d = 8'b1000_1001;
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
            FLASH:    lamps_d = {1'b0, flash_d, 2'b00, 1'b0, flash_d, 2'b00};
`endif
            default:  lamps_d = 8'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset1) begin
            tick_q     <= '0;
            sec_tick_q <= 1'b0;
            state_q    <= G1;
            cnt_q      <= green_ld;
            pend1_q    <= 1'b0;
            pend2_q    <= 1'b0;
            lamps_q    <= 8'b0010_1000;
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
            flash_q    <= 1'b0;
`endif
        end else begin
            tick_q     <= tick_d;
            sec_tick_q <= tick_hit;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend2_d;
            lamps_q    <= lamps_d;
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
            flash_q    <= flash_d;
`endif
        end
    end

    assign {bus.Red1, bus.Yellow1, bus.Green1, bus.Left1} = lamps_q[7:4];
    assign {bus.Red2, bus.Yellow2, bus.Green2, bus.Left2} = lamps_q[3:0];
    assign bus.countdown = cnt_q;
    assign bus.phase     = state_q[2:0];
    assign bus.sec_tick  = sec_tick_q;
endmodule

// File: tb/tb_light_phase_scheduler.sv
// Directed bench for light_phase_scheduler: phase order, tick rates, left-turn arbitration, freeze, reset.
module tb_light_phase_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   zero_seen = 0;
    logic mon_zero = 1'b1;

    localparam logic [7:0] LG1 = 8'b0010_1000;
    localparam logic [7:0] LY1 = 8'b0100_1000;
    localparam logic [7:0] LL1 = 8'b1001_1000;
    localparam logic [7:0] LG2 = 8'b1000_0010;
    localparam logic [7:0] LY2 = 8'b1000_0100;
    localparam logic [7:0] LL2 = 8'b1000_1001;

    light_phase_if bus ();

    light_phase_scheduler #(.TICK_DIV(16), .GREEN_T(30), .YELLOW_T(3), .LEFT_T(10)) dut (
        .CLK(clk), .Reset1(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon_zero && !rst && bus.countdown == 8'd0) zero_seen <= zero_seen + 1;

    function automatic logic [7:0] lamps();
        return {bus.Red1, bus.Yellow1, bus.Green1, bus.Left1, bus.Red2, bus.Yellow2, bus.Green2, bus.Left2};
    endfunction

    task automatic wait_tick(input int n);
        int seen = 0;
        int guard = 0;
        while (seen < n && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
            if (bus.sec_tick) seen++;
        end
        if (seen < n) begin
            checks++; failures++;
            $display("FAIL wait_tick timeout: saw %0d of %0d ticks", seen, n);
        end
    endtask

    task automatic do_reset(input logic [2:0] fs, input logic [1:0] spd);
        bus.flowspeed = fs; bus.speed_select = spd; bus.count_en = 1'b1;
        bus.turn_left_req = 4'b0; bus.SW = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.flowspeed = 3'd1; bus.speed_select = 2'd0; bus.count_en = 1'b1;
        bus.turn_left_req = 4'b1111; bus.SW = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.phase !== 3'd0) begin failures++; $display("FAIL reset_phase got %0d want 0", bus.phase); end
        checks++; if (bus.countdown !== 8'd32) begin failures++; $display("FAIL reset_countdown got %0d want 32", bus.countdown); end
        checks++; if (lamps() !== LG1) begin failures++; $display("FAIL reset_lamps got %b want %b", lamps(), LG1); end
        checks++; if (bus.sec_tick !== 1'b0) begin failures++; $display("FAIL reset_sec_tick got %b want 0", bus.sec_tick); end
        checks++; if ({dut.pend1_q, dut.pend2_q} !== 2'b00) begin failures++; $display("FAIL reset_pend got %b want 00", {dut.pend1_q, dut.pend2_q}); end
        bus.turn_left_req = 4'b0;
    endtask

    task automatic test_phase_cycle();
        int c0;
        do_reset(3'd1, 2'd0);
        wait_tick(1);
        checks++; if (bus.countdown !== 8'd31) begin failures++; $display("FAIL first_tick_countdown got %0d want 31", bus.countdown); end
        @(posedge clk); #1;
        checks++; if (bus.sec_tick !== 1'b0) begin failures++; $display("FAIL sec_tick_width got %b want 0", bus.sec_tick); end
        wait_tick(1);
        c0 = cyc;
        wait_tick(1);
        checks++; if (cyc - c0 !== 16) begin failures++; $display("FAIL tick_period_1x got %0d want 16", cyc - c0); end
        wait_tick(29);
        checks++; if (bus.phase !== 3'd1 || bus.countdown !== 8'd3 || lamps() !== LY1) begin failures++; $display("FAIL enter_Y1 got ph=%0d cd=%0d lamps=%b want ph=1 cd=3 lamps=%b", bus.phase, bus.countdown, lamps(), LY1); end
        wait_tick(3);
        checks++; if (bus.phase !== 3'd4 || bus.countdown !== 8'd32 || lamps() !== LG2) begin failures++; $display("FAIL skip_to_G2 got ph=%0d cd=%0d lamps=%b want ph=4 cd=32 lamps=%b", bus.phase, bus.countdown, lamps(), LG2); end
        wait_tick(32);
        checks++; if (bus.phase !== 3'd5 || bus.countdown !== 8'd3 || lamps() !== LY2) begin failures++; $display("FAIL enter_Y2 got ph=%0d cd=%0d lamps=%b want ph=5 cd=3 lamps=%b", bus.phase, bus.countdown, lamps(), LY2); end
        wait_tick(3);
        checks++; if (bus.phase !== 3'd0 || bus.countdown !== 8'd32 || lamps() !== LG1) begin failures++; $display("FAIL wrap_to_G1 got ph=%0d cd=%0d lamps=%b want ph=0 cd=32", bus.phase, bus.countdown, lamps()); end
    endtask

    task automatic test_speed_select();
        int c0;
        do_reset(3'd1, 2'd3);
        wait_tick(1);
        c0 = cyc;
        wait_tick(1);
        checks++; if (cyc - c0 !== 2) begin failures++; $display("FAIL tick_period_8x got %0d want 2", cyc - c0); end
        wait_tick(68);
        checks++; if (bus.phase !== 3'd0 || bus.countdown !== 8'd32) begin failures++; $display("FAIL speed8_G1 got ph=%0d cd=%0d want ph=0 cd=32", bus.phase, bus.countdown); end
        c0 = cyc;
        wait_tick(35);
        checks++; if (bus.phase !== 3'd4) begin failures++; $display("FAIL speed8_G2 got ph=%0d want 4", bus.phase); end
        wait_tick(35);
        checks++; if (cyc - c0 !== 140) begin failures++; $display("FAIL full_cycle_8x got %0d want 140", cyc - c0); end
    endtask

    task automatic test_left_turn();
        do_reset(3'd1, 2'd3);
        wait_tick(1);
        bus.turn_left_req = 4'b0010;
        @(posedge clk); #1;
        bus.turn_left_req = 4'b0;
        wait_tick(34);
        checks++; if (bus.phase !== 3'd2 || bus.countdown !== 8'd10 || lamps() !== LL1) begin failures++; $display("FAIL enter_L1 got ph=%0d cd=%0d lamps=%b want ph=2 cd=10 lamps=%b", bus.phase, bus.countdown, lamps(), LL1); end
        checks++; if (dut.pend1_q !== 1'b0) begin failures++; $display("FAIL pend1_clear got %b want 0", dut.pend1_q); end
        wait_tick(10);
        checks++; if (bus.phase !== 3'd3 || bus.countdown !== 8'd3 || lamps() !== LY1) begin failures++; $display("FAIL enter_LY1 got ph=%0d cd=%0d lamps=%b want ph=3 cd=3", bus.phase, bus.countdown, lamps()); end
        wait_tick(3);
        checks++; if (bus.phase !== 3'd4 || bus.countdown !== 8'd32) begin failures++; $display("FAIL LY1_to_G2 got ph=%0d cd=%0d want ph=4 cd=32", bus.phase, bus.countdown); end
        wait_tick(70);
        checks++; if (bus.phase !== 3'd4) begin failures++; $display("FAIL L1_not_repeated got ph=%0d want 4", bus.phase); end
    endtask

    task automatic test_left_held();
        do_reset(3'd1, 2'd3);
        bus.turn_left_req = 4'b0100;
        wait_tick(70);
        checks++; if (bus.phase !== 3'd6 || bus.countdown !== 8'd10 || lamps() !== LL2) begin failures++; $display("FAIL enter_L2 got ph=%0d cd=%0d lamps=%b want ph=6 cd=10 lamps=%b", bus.phase, bus.countdown, lamps(), LL2); end
        checks++; if (dut.pend2_q !== 1'b0) begin failures++; $display("FAIL pend2_clear_wins got %b want 0", dut.pend2_q); end
        @(posedge clk); #1;
        checks++; if (dut.pend2_q !== 1'b1) begin failures++; $display("FAIL pend2_reset got %b want 1", dut.pend2_q); end
        bus.turn_left_req = 4'b0;
        wait_tick(83);
        checks++; if (bus.phase !== 3'd6 || lamps() !== LL2) begin failures++; $display("FAIL L2_served_again got ph=%0d lamps=%b want ph=6", bus.phase, lamps()); end
    endtask

    task automatic test_freeze();
        int ticks_seen = 0;
        do_reset(3'd1, 2'd3);
        wait_tick(62);
        checks++; if (bus.phase !== 3'd4 || bus.countdown !== 8'd5) begin failures++; $display("FAIL pre_freeze got ph=%0d cd=%0d want ph=4 cd=5", bus.phase, bus.countdown); end
        bus.count_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.turn_left_req = (i == 40) ? 4'b1000 : 4'b0000;
            @(posedge clk); #1;
            if (bus.sec_tick) ticks_seen++;
        end
        bus.turn_left_req = 4'b0;
        checks++; if (ticks_seen !== 0) begin failures++; $display("FAIL freeze_no_tick got %0d want 0", ticks_seen); end
        checks++; if (bus.phase !== 3'd4 || bus.countdown !== 8'd5) begin failures++; $display("FAIL freeze_hold got ph=%0d cd=%0d want ph=4 cd=5", bus.phase, bus.countdown); end
        checks++; if (dut.pend2_q !== 1'b1) begin failures++; $display("FAIL freeze_pend_latch got %b want 1", dut.pend2_q); end
        bus.count_en = 1'b1;
        wait_tick(1);
        checks++; if (bus.countdown !== 8'd4) begin failures++; $display("FAIL resume_countdown got %0d want 4", bus.countdown); end
        wait_tick(7);
        checks++; if (bus.phase !== 3'd6 || bus.countdown !== 8'd10) begin failures++; $display("FAIL freeze_req_served got ph=%0d cd=%0d want ph=6 cd=10", bus.phase, bus.countdown); end
    endtask

    task automatic test_reset_mid_l1();
        do_reset(3'd1, 2'd3);
        wait_tick(1);
        bus.turn_left_req = 4'b1001;
        @(posedge clk); #1;
        bus.turn_left_req = 4'b0;
        wait_tick(34);
        checks++; if (bus.phase !== 3'd2) begin failures++; $display("FAIL reach_L1 got ph=%0d want 2", bus.phase); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.phase !== 3'd0 || bus.countdown !== 8'd32 || lamps() !== LG1) begin failures++; $display("FAIL mid_reset got ph=%0d cd=%0d lamps=%b want ph=0 cd=32 lamps=%b", bus.phase, bus.countdown, lamps(), LG1); end
        checks++; if ({dut.pend1_q, dut.pend2_q} !== 2'b00) begin failures++; $display("FAIL mid_reset_pend got %b want 00", {dut.pend1_q, dut.pend2_q}); end
    endtask

    task automatic test_flowspeed();
        do_reset(3'd7, 2'd3);
        checks++; if (bus.countdown !== 8'd44) begin failures++; $display("FAIL green_max_load got %0d want 44", bus.countdown); end
        wait_tick(44);
        checks++; if (bus.phase !== 3'd1 || bus.countdown !== 8'd3) begin failures++; $display("FAIL green_max_len got ph=%0d cd=%0d want ph=1 cd=3", bus.phase, bus.countdown); end
        bus.flowspeed = 3'd0;
        wait_tick(3);
        checks++; if (bus.phase !== 3'd4 || bus.countdown !== 8'd30) begin failures++; $display("FAIL green_min_load got ph=%0d cd=%0d want ph=4 cd=30", bus.phase, bus.countdown); end
    endtask

`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
    task automatic test_flash();
        mon_zero = 1'b0;
        do_reset(3'd1, 2'd3);
        wait_tick(2);
        bus.SW = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.phase !== 3'd0 || bus.countdown !== 8'd0 || lamps() !== 8'b0) begin failures++; $display("FAIL flash_enter got ph=%0d cd=%0d lamps=%b want 0 0 0", bus.phase, bus.countdown, lamps()); end
        wait_tick(1);
        checks++; if (lamps() !== 8'b0100_0100) begin failures++; $display("FAIL flash_on got %b want 01000100", lamps()); end
        wait_tick(1);
        checks++; if (lamps() !== 8'b0) begin failures++; $display("FAIL flash_off got %b want 0", lamps()); end
        bus.SW = 1'b0;
        wait_tick(1);
        checks++; if (bus.phase !== 3'd0 || bus.countdown !== 8'd32 || lamps() !== LG1) begin failures++; $display("FAIL flash_exit got ph=%0d cd=%0d lamps=%b want ph=0 cd=32", bus.phase, bus.countdown, lamps()); end
        mon_zero = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_phase_cycle();
        test_speed_select();
        test_left_turn();
        test_left_held();
        test_freeze();
        test_reset_mid_l1();
        test_flowspeed();
`ifdef LIGHT_PHASE_NIGHT_FLASH_EN
        test_flash();
`endif
        checks++; if (zero_seen !== 0) begin failures++; $display("FAIL countdown_zero got %0d cycles want 0", zero_seen); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
